// File: rtl/shift_pkg.sv
// Shared types and the ladder-level to pipeline-stage mapping for shift_pipe.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    // Stage that owns ladder level `level` when `levels` levels are spread over `stages` stages.
    function automatic int level_stage(input int level, input int stages, input int levels);
        return (level * stages) / levels;
    endfunction

    // Lowest ladder level owned by `stage`; returns `levels` for stage == stages.
    function automatic int stage_first_level(input int stage, input int stages, input int levels);
        int first;
        first = levels;
        for (int i = levels - 1; i >= 0; i--) begin
            if (level_stage(i, stages, levels) >= stage) first = i;
        end
        return first;
    endfunction

endpackage

// File: rtl/shift_levels.sv
// Combinational slice of the right-shift/rotate ladder: applies levels LO..HI.
module shift_levels
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int LO   = 0,
    parameter int HI   = 0
) (
    input  shift_op_e         op,
    input  logic              sign,
    input  logic [XLEN-1:0]   din,
    input  logic [HI-LO:0]    shamt,
    output logic [XLEN-1:0]   dout
);

    logic            fill;
    logic [XLEN-1:0] hi;
    logic [HI-LO:0]  sh;

    assign fill = sign && (op == SHIFT_SRA);

    // NOTE: blocking assignments here let each level consume the previous level's result inside one combinational block.
    always_comb begin
        hi   = '0;
        sh   = shamt;
        dout = din;
        for (int i = LO; i <= HI; i++) begin
            hi = (op == SHIFT_ROR) ? dout : {XLEN{fill}};
            if (sh[0]) dout = XLEN'({hi, dout} >> (1 << i));
            sh = sh >> 1;
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with a valid/ready elastic handshake.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [XLEN-1:0]         in_data,
    input  logic [$clog2(XLEN)-1:0] in_shamt,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int L = $clog2(XLEN);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] rdy;
    shift_op_e         op_q   [STAGES];
    logic              sign_q [STAGES];
    logic [L-1:0]      sh_q   [STAGES];
    logic [XLEN-1:0]   data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];

    logic              src_vld  [STAGES];
    shift_op_e         src_op   [STAGES];
    logic              src_sign [STAGES];
    logic [L-1:0]      src_sh   [STAGES];
    logic [XLEN-1:0]   src_data [STAGES];
    logic [TAG_W-1:0]  src_tag  [STAGES];
    logic [XLEN-1:0]   lvl_out  [STAGES];

    shift_op_e         in_op_e;
    logic [XLEN-1:0]   in_data_rev;
    logic [XLEN-1:0]   out_data_rev;

    // SLL runs through the right-shift ladder on bit-reversed data.
    assign in_op_e      = shift_op_e'(in_op);
    assign in_data_rev  = {<<{in_data}};
    assign out_data_rev = {<<{data_q[STAGES-1]}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = stage_first_level(k, STAGES, L);
        localparam int HI = stage_first_level(k + 1, STAGES, L) - 1;

        if (k == 0) begin : g_src
            assign src_vld[k]  = in_valid;
            assign src_op[k]   = in_op_e;
            assign src_sign[k] = in_data[XLEN-1];
            assign src_sh[k]   = in_shamt;
            assign src_data[k] = (in_op_e == SHIFT_SLL) ? in_data_rev : in_data;
            assign src_tag[k]  = in_tag;
        end else begin : g_src
            assign src_vld[k]  = vld_q[k-1];
            assign src_op[k]   = op_q[k-1];
            assign src_sign[k] = sign_q[k-1];
            assign src_sh[k]   = sh_q[k-1];
            assign src_data[k] = data_q[k-1];
            assign src_tag[k]  = tag_q[k-1];
        end

        // A stage may load unless it and every stage after it are full and the output is stalled.
        assign rdy[k] = out_ready || !(&vld_q[STAGES-1:k]);

        shift_levels #(
            .XLEN (XLEN),
            .LO   (LO),
            .HI   (HI)
        ) u_levels (
            .op    (src_op[k]),
            .sign  (src_sign[k]),
            .din   (src_data[k]),
            .shamt (src_sh[k][HI:LO]),
            .dout  (lvl_out[k])
        );
    end

    // NOTE: payload registers are cleared along with the valid bits so out_data/out_tag read 0 straight after reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rst) begin
                vld_q[k]  <= 1'b0;
                op_q[k]   <= SHIFT_SLL;
                sign_q[k] <= 1'b0;
                sh_q[k]   <= '0;
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end else if (rdy[k]) begin
                vld_q[k]  <= src_vld[k];
                op_q[k]   <= src_op[k];
                sign_q[k] <= src_sign[k];
                sh_q[k]   <= src_sh[k];
                data_q[k] <= lvl_out[k];
                tag_q[k]  <= src_tag[k];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = (op_q[STAGES-1] == SHIFT_SLL) ? out_data_rev : data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed-vector and scoreboard bench for shift_pipe at XLEN=32, STAGES=2, TAG_W=5.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
    localparam int NVEC   = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_data;
    logic [4:0]       in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    shift_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    typedef struct {
        shift_op_e   op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t                      vecs [NVEC];
    logic [TAG_W+XLEN-1:0]     exp_q [$];
    logic [TAG_W+XLEN-1:0]     mon_e;
    int                        n_checks = 0;
    int                        n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every popped result must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_result: got tag %0d data 0x%h, expected no result", out_tag, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_data", 64'(out_data), 64'(mon_e[XLEN-1:0]));
                check("result_tag", 64'(out_tag), 64'(mon_e[TAG_W+XLEN-1:XLEN]));
            end
        end
    end

    function automatic logic [31:0] model(input shift_op_e op, input logic [31:0] d, input logic [4:0] s);
        case (op)
            SHIFT_SLL: return d << s;
            SHIFT_SRL: return d >> s;
            SHIFT_SRA: return 32'($signed(d) >>> s);
            default:   return (d >> s) | (d << (32 - int'(s)));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted; records the expected result.
    task automatic push(input shift_op_e op, input logic [31:0] d, input logic [4:0] s,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        int waits = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0 for tag %0d, expected acceptance", tag);
        end else begin
            exp_q.push_back({tag, exp});
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{SHIFT_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[1]  = '{SHIFT_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[2]  = '{SHIFT_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[3]  = '{SHIFT_ROR, 32'h0000_00FF, 5'd4,  32'hF000_000F};
        vecs[4]  = '{SHIFT_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[5]  = '{SHIFT_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[6]  = '{SHIFT_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[7]  = '{SHIFT_ROR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[8]  = '{SHIFT_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[9]  = '{SHIFT_SRA, 32'hFFFF_FFFE, 5'd1,  32'hFFFF_FFFF};
        vecs[10] = '{SHIFT_ROR, 32'h1234_5678, 5'd16, 32'h5678_1234};
        vecs[11] = '{SHIFT_SLL, 32'hDEAD_BEEF, 5'd8,  32'hADBE_EF00};
        vecs[12] = '{SHIFT_SRA, 32'hDEAD_BEEF, 5'd8,  32'hFFDE_ADBE};
        vecs[13] = '{SHIFT_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[14] = '{SHIFT_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        in_shamt  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) step();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        step();

        // Back-to-back table vectors; the first two also pin down the two-cycle latency.
        push(vecs[0].op, vecs[0].data, vecs[0].shamt, 5'd1, vecs[0].exp);
        check("latency_not_yet_valid", 64'(out_valid), 64'd0);
        push(vecs[1].op, vecs[1].data, vecs[1].shamt, 5'd2, vecs[1].exp);
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_first_tag", 64'(out_tag), 64'd1);
        for (int i = 2; i < NVEC; i++)
            push(vecs[i].op, vecs[i].data, vecs[i].shamt, TAG_W'(i + 1), vecs[i].exp);
        drain();

        // Backpressure: two requests fill the pipe, the third waits while output is stalled.
        out_ready = 1'b0;
        push(SHIFT_SRL, 32'hA5A5_0000, 5'd8, 5'd20, 32'h00A5_A500);
        push(SHIFT_SLL, 32'h0000_0003, 5'd2, 5'd21, 32'h0000_000C);
        in_valid = 1'b1;
        in_op    = SHIFT_ROR;
        in_data  = 32'h0000_0010;
        in_shamt = 5'd8;
        in_tag   = 5'd22;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data", 64'(out_data), 64'h00A5_A500);
            step();
            in_data = 32'(c);
            in_op   = SHIFT_SRA;
        end
        in_op    = SHIFT_ROR;
        in_data  = 32'h0000_0010;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({5'd22, 32'h1000_0000});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_no_bubble_1", 64'(out_valid), 64'd1);
        step();
        @(negedge clk);
        check("drain_no_bubble_2", 64'(out_valid), 64'd1);
        drain();

        // Full pipe: one pop and one push on the same edge leave it full.
        out_ready = 1'b0;
        push(SHIFT_SRA, 32'hF000_0000, 5'd28, 5'd23, 32'hFFFF_FFFF);
        push(SHIFT_SRL, 32'hF000_0000, 5'd28, 5'd24, 32'h0000_000F);
        in_valid  = 1'b1;
        in_op     = SHIFT_SLL;
        in_data   = 32'h0000_00F0;
        in_shamt  = 5'd24;
        in_tag    = 5'd25;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pushpop_in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({5'd25, 32'hF000_0000});
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("full_still_full", 64'(in_ready), 64'd0);
        check("full_head_tag", 64'(out_tag), 64'd24);
        step();
        drain();

        // Reset with two results in flight: both are discarded.
        out_ready = 1'b0;
        push(SHIFT_SRL, 32'h1111_1111, 5'd1, 5'd26, 32'h0888_8888);
        push(SHIFT_SRL, 32'h2222_2222, 5'd1, 5'd27, 32'h1111_1111);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_data", 64'(out_data), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("midreset_no_stale", 64'(out_valid), 64'd0);
        end
        push(SHIFT_SRL, 32'h0000_00F0, 5'd4, 5'd9, 32'h0000_000F);
        drain();

        // Random traffic with random valid/ready against the reference model.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_tag    = TAG_W'(c);
            @(negedge clk);
            if (in_valid && in_ready)
                exp_q.push_back({in_tag, model(shift_op_e'(in_op), in_data, in_shamt)});
            step();
        end
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the RISC-V execute datapath.
- Successor to the fixed 32-bit, combinational, logical-right-only shifter.
- Supports SLL, SRL, SRA and ROR at any power-of-two XLEN.
- Shift ladder is split across STAGES register stages with a valid/ready elastic handshake, so the shifter can be retimed against the ALU critical path and can absorb stalls.

Parameters:
- XLEN, 32: data width; power of two, 8..64.
- STAGES, 2: number of register stages; 1..$clog2(XLEN).
- TAG_W, 5: width of opaque sideband tag (e.g. rd index), carried unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  2  shift_op_e: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_data  in  XLEN  operand.
- in_shamt  in  $clog2(XLEN)  shift amount; upper operand bits are already dropped by the caller.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear; all stage data/tag/op/shamt registers clear to 0.
  - Hence out_valid=0, out_data=0, out_tag=0 in the cycle after reset.
  - in_ready=1 whenever the pipe is empty.
  - Reset mid-operation discards all in-flight results; none are emitted.
- Shift ladder:
  - L=$clog2(XLEN) levels; level i shifts by 2^i when shamt[i]=1.
  - Level i is placed in stage floor(i*STAGES/L).
  - Each stage ends in a register holding {valid, op, remaining shamt bits, partial data, tag}.
  - out_* are driven directly from the last stage register.
- Op rules:
  - SRL fills with 0.
  - SRA fills with data[XLEN-1] of the original operand; the sign bit is captured at the input and carried through the stages.
  - ROR feeds low bits back to the top.
  - SLL is computed as reverse(SRL(reverse(data))); the reversal is applied at input and output (combinational, no extra latency).
- shamt=0 passes data through unchanged for all ops.
- Latency: exactly STAGES cycles from the in_valid&&in_ready edge to out_valid, when out_ready is held 1. Throughput is 1 result per cycle.
- Handshake:
  - A transfer occurs on any edge where valid&&ready.
  - Stage k advances when its successor is empty or the successor is advancing; the last stage advances on out_ready.
  - in_ready = !stage0.valid || stage0 advances. The ready chain is combinational back from out_ready; there is no combinational path from in_valid to out_valid.
  - While out_valid=1 and out_ready=0: out_data/out_tag are held stable, out_valid is held at 1, and stages fill up behind.
  - in_ready drops only when all STAGES stages hold valid entries and out_ready=0.
  - Simultaneous output pop and input push when full: both complete in the same cycle, no bubble.
- Ordering: results leave strictly in request order. No entry is dropped or duplicated.
- Inputs are ignored when in_valid=0. in_* may change freely while in_ready=0.

Decomposition:
- Package shift_pkg:
  - shift_op_e enum (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR).
  - Function for the level-to-stage mapping.
- Sub-module shift_levels: purely combinational. Applies levels [LO..HI] of the right-shift/rotate ladder for one stage, given op, fill bit and shamt slice.
- shift_pipe instantiates STAGES copies of shift_levels and owns the handshake registers.

Test Plan (XLEN=32, STAGES=2, TAG_W=5):
- Basic ops. Back-to-back pushes with out_ready=1:
  - SRA 0x8000_0000 by 4 -> 0xF800_0000.
  - SRL 0x8000_0000 by 4 -> 0x0800_0000.
  - SLL 0x0000_0001 by 31 -> 0x8000_0000.
  - ROR 0x0000_00FF by 4 -> 0xF000_000F.
  - Each out_valid rises 2 cycles after acceptance; tags 1..4 come out in order.
- Edge amounts: shamt 0 on each op with 0xDEAD_BEEF -> 0xDEAD_BEEF. SRA 0x7FFF_FFFF by 31 -> 0x0000_0000. SRA 0xFFFF_FFFE by 1 -> 0xFFFF_FFFF.
- Backpressure: hold out_ready=0 and push 3 requests.
  - First 2 are accepted, then in_ready=0.
  - out_data stays stable for the whole stall.
  - Releasing out_ready drains 3 results in order with no bubble.
- Full-pipe push/pop: pipe full, out_ready=1 and in_valid=1 on the same edge -> one pop and one push that cycle; occupancy unchanged.
- Reset mid-flight: assert rst for 1 cycle with 2 entries in flight.
  - Next cycle out_valid=0, out_data=0, in_ready=1.
  - No stale result ever appears.
- Random: 10k random op/data/shamt with random valid/ready, checked against a reference model. Zero mismatches, ordering preserved, all configs STAGES=1..5.
